// File: rtl/delay_credit_ctrl.sv
// delay_credit_ctrl: sequences a fixed-latency delay line feeding a BUF_DEPTH-entry buffer.
// Tracks per-slot valid bits alongside the data, throttles the producer with credits and
// provides a flush/drain sequence that reports completion with a one-cycle pulse.
module delay_credit_ctrl #(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned BUF_DEPTH = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             OUT_VALID,
    input  logic             BUF_POP,
    output logic [CNT_W-1:0] CREDITS,
    output logic [CNT_W-1:0] INFLIGHT,
    output logic             BUSY,
    output logic             FLUSH_DONE,
    output logic             CREDIT_ERR
);

    localparam logic [CNT_W-1:0] CreditsFull = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e             state_q;
    logic [LATENCY-1:0] vpipe_q, vpipe_d;
    logic [CNT_W-1:0]   credits_q, credits_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic               credit_err_q, credit_err_d;
    logic               flush_done_q;
    logic               accept;
    logic               pipe_empty_next;

    assign IN_READY   = (state_q == StRun) && (credits_q != '0);
    assign accept     = IN_VALID & IN_READY;
    assign OUT_VALID  = vpipe_q[LATENCY-1];
    assign CREDITS    = credits_q;
    assign INFLIGHT   = inflight_q;
    assign CREDIT_ERR = credit_err_q;
    assign FLUSH_DONE = flush_done_q;
    assign BUSY       = (state_q != StIdle) || (inflight_q != '0);

    // Pipe is empty after this edge; in DRAIN (no accepts) this covers the last word leaving now.
    assign pipe_empty_next = (inflight_d == '0);

    // Next-state for the valid pipe, in-flight count and credit bookkeeping.
    always_comb begin
        vpipe_d      = vpipe_q << 1;
        vpipe_d[0]   = accept;

        inflight_d   = inflight_q;
        if (accept && !OUT_VALID) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!accept && OUT_VALID) begin
            inflight_d = inflight_q - CNT_W'(1);
        end

        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        if (accept && !BUF_POP) begin
            credits_d = credits_q - CNT_W'(1);
        end else if (BUF_POP && !accept) begin
            if (credits_q == CreditsFull) begin
                // Pop with nothing outstanding: saturate and flag the consumer's mistake.
                credit_err_d = 1'b1;
            end else begin
                credits_d = credits_q + CNT_W'(1);
            end
        end
    end

    // Datapath bookkeeping registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vpipe_q      <= '0;
            inflight_q   <= '0;
            credits_q    <= CreditsFull;
            credit_err_q <= 1'b0;
        end else begin
            vpipe_q      <= vpipe_d;
            inflight_q   <= inflight_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
        end
    end

    // Control FSM with registered drain-complete pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= StIdle;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (FLUSH) begin
                        // Already empty: finish immediately so the pulse lands one cycle later.
                        if (pipe_empty_next) begin
                            flush_done_q <= 1'b1;
                        end else begin
                            state_q <= StDrain;
                        end
                    end else if (ENABLE) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (FLUSH) begin
                        if (pipe_empty_next) begin
                            state_q      <= StIdle;
                            flush_done_q <= 1'b1;
                        end else begin
                            state_q <= StDrain;
                        end
                    end else if (!ENABLE) begin
                        state_q <= StIdle;
                    end
                end
                StDrain: begin
                    if (pipe_empty_next) begin
                        state_q      <= StIdle;
                        flush_done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_credit_ctrl.sv
// Directed bench for delay_credit_ctrl with a bench-side 4-stage data delay line.
module tb_delay_credit_ctrl;

    localparam int unsigned LATENCY   = 4;
    localparam int unsigned BUF_DEPTH = 8;
    localparam int unsigned CNT_W     = 4;

    logic             CLK;
    logic             RESET;
    logic             ENABLE;
    logic             FLUSH;
    logic             IN_VALID;
    logic             IN_READY;
    logic             OUT_VALID;
    logic             BUF_POP;
    logic [CNT_W-1:0] CREDITS;
    logic [CNT_W-1:0] INFLIGHT;
    logic             BUSY;
    logic             FLUSH_DONE;
    logic             CREDIT_ERR;

    logic [7:0] din;
    logic [7:0] dline_q [LATENCY];

    int unsigned n_checks;
    int unsigned n_errors;

    delay_credit_ctrl #(
        .LATENCY  (LATENCY),
        .BUF_DEPTH(BUF_DEPTH),
        .CNT_W    (CNT_W)
    ) u_dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ENABLE    (ENABLE),
        .FLUSH     (FLUSH),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT_VALID (OUT_VALID),
        .BUF_POP   (BUF_POP),
        .CREDITS   (CREDITS),
        .INFLIGHT  (INFLIGHT),
        .BUSY      (BUSY),
        .FLUSH_DONE(FLUSH_DONE),
        .CREDIT_ERR(CREDIT_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Stand-in for the delay instance the controller sequences.
    always_ff @(posedge CLK) begin
        dline_q[0] <= din;
        for (int i = 1; i < LATENCY; i++) begin
            dline_q[i] <= dline_q[i-1];
        end
    end

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int outs;
        int last_out;
        int done_at;

        n_checks = 0;
        n_errors = 0;
        RESET    = 1'b1;
        ENABLE   = 1'b0;
        FLUSH    = 1'b0;
        IN_VALID = 1'b1;
        BUF_POP  = 1'b0;
        din      = 8'h00;

        // Reset / idle
        tick();
        tick();
        RESET = 1'b0;
        tick();
        check_eq("rst_in_ready", IN_READY, 0);
        check_eq("rst_credits", CREDITS, 8);
        check_eq("rst_inflight", INFLIGHT, 0);
        check_eq("rst_out_valid", OUT_VALID, 0);
        check_eq("rst_credit_err", CREDIT_ERR, 0);
        check_eq("rst_busy", BUSY, 0);
        IN_VALID = 1'b0;

        // Latency: one word with 0xA5
        ENABLE = 1'b1;
        tick();
        check_eq("run_in_ready", IN_READY, 1);
        IN_VALID = 1'b1;
        din      = 8'hA5;
        tick();
        IN_VALID = 1'b0;
        din      = 8'h00;
        for (int k = 1; k <= 4; k++) begin
            check_eq("lat_inflight", INFLIGHT, 1);
            check_eq("lat_out_valid", OUT_VALID, (k == 4) ? 1 : 0);
            if (k == 4) check_eq("lat_dout", dline_q[LATENCY-1], 8'hA5);
            tick();
        end
        check_eq("lat_inflight_after", INFLIGHT, 0);
        check_eq("lat_out_valid_after", OUT_VALID, 0);
        check_eq("lat_credits", CREDITS, 7);
        BUF_POP = 1'b1;
        tick();
        BUF_POP = 1'b0;
        check_eq("lat_credits_back", CREDITS, 8);

        // Backpressure
        IN_VALID = 1'b1;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (IN_READY) acc++;
            tick();
        end
        check_eq("bp_accepts", acc, 8);
        check_eq("bp_credits0", CREDITS, 0);
        check_eq("bp_ready0", IN_READY, 0);
        BUF_POP = 1'b1;
        tick();
        BUF_POP = 1'b0;
        check_eq("bp_credits1", CREDITS, 1);
        check_eq("bp_ready1", IN_READY, 1);
        tick();
        check_eq("bp_credits_re0", CREDITS, 0);
        check_eq("bp_ready_re0", IN_READY, 0);
        IN_VALID = 1'b0;

        // Simultaneous accept and pop
        BUF_POP = 1'b1;
        tick();
        tick();
        tick();
        check_eq("sim_credits3", CREDITS, 3);
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        check_eq("sim_credits_hold", CREDITS, 3);
        for (int i = 0; i < 5; i++) tick();
        check_eq("sim_credits8", CREDITS, 8);
        check_eq("sim_err_clear", CREDIT_ERR, 0);
        tick();
        BUF_POP = 1'b0;
        check_eq("sim_err_set", CREDIT_ERR, 1);
        check_eq("sim_credits_sat", CREDITS, 8);
        tick();
        check_eq("sim_err_sticky", CREDIT_ERR, 1);
        check_eq("sim_inflight0", INFLIGHT, 0);

        // Flush with three words in flight (relative cycle 0 = first accept)
        IN_VALID = 1'b1;
        tick();
        tick();
        tick();
        IN_VALID = 1'b0;
        FLUSH    = 1'b1;
        tick();
        FLUSH = 1'b0;
        check_eq("fl_ready_off", IN_READY, 0);
        check_eq("fl_busy", BUSY, 1);
        outs     = 0;
        last_out = -1;
        done_at  = -1;
        for (int rel = 4; rel < 24; rel++) begin
            if (OUT_VALID) begin
                outs++;
                last_out = rel;
            end
            if (FLUSH_DONE) begin
                done_at = rel;
                check_eq("fl_busy_done", BUSY, 0);
                break;
            end
            check_eq("fl_ready_drain", IN_READY, 0);
            tick();
        end
        check_eq("fl_outs", outs, 3);
        check_eq("fl_last_out", last_out, 6);
        check_eq("fl_done_at", done_at, 7);
        check_eq("fl_credits_kept", CREDITS, 5);
        tick();
        check_eq("fl_done_pulse", FLUSH_DONE, 0);

        // Flush with an empty pipe from RUN
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        check_eq("fe_done", FLUSH_DONE, 1);
        check_eq("fe_busy", BUSY, 0);
        tick();
        check_eq("fe_done_low", FLUSH_DONE, 0);

        // Reset mid-operation: 2 in flight, credits 5
        BUF_POP = 1'b1;
        tick();
        tick();
        BUF_POP  = 1'b0;
        IN_VALID = 1'b1;
        tick();
        tick();
        IN_VALID = 1'b0;
        check_eq("mr_inflight2", INFLIGHT, 2);
        check_eq("mr_credits5", CREDITS, 5);
        RESET  = 1'b1;
        ENABLE = 1'b0;
        tick();
        RESET = 1'b0;
        check_eq("mr_inflight0", INFLIGHT, 0);
        check_eq("mr_credits8", CREDITS, 8);
        check_eq("mr_err_clear", CREDIT_ERR, 0);
        for (int i = 0; i < 4; i++) begin
            check_eq("mr_out_valid", OUT_VALID, 0);
            check_eq("mr_ready", IN_READY, 0);
            tick();
        end
        ENABLE = 1'b1;
        tick();
        check_eq("mr_ready_en", IN_READY, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
